regression_stat_accumulator: RTL

- Sits directly downstream of the sample-index counter in the linear-regression datapath.
- Walks N samples, consumes one (x, y) pair per accepted beat, and accumulates the four sums the coefficient stage needs: Σx, Σy, Σx², Σxy.
- Owns its own modulo-N sample index, which drives the sample-memory address.
- Pulses done when all sums are final, then holds them for the coefficient calculator.

---
 rtl/regression_stat_accumulator.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/regression_stat_accumulator.sv
// regression_stat_accumulator
// Accumulates sum(x), sum(y), sum(x*x) and sum(x*y) over a run of N_SAMPLES
// signed (x, y) pairs for the linear-regression coefficient stage. The block
// owns a modulo-N sample index that addresses sample memory, pulses done for
// one cycle when the sums are final, and then holds them until the next start.
//
// Handshake: a sample is accepted on a rising edge where in_valid & in_ready.
// in_ready is high for the whole ACCUM state and is derived from state only,
// never from in_valid. The producer must hold x_in/y_in while in_valid is
// high and in_ready is low. Stalls (in_valid low) may last any number of cycles.
module regression_stat_accumulator #(
  parameter int WORD_LEN  = 8,
  parameter int N_SAMPLES = 150,
  parameter int CNT_LEN   = 8,
  parameter int LIN_LEN   = 16,
  parameter int SQ_LEN    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_LEN-1:0] x_in,
  input  logic [WORD_LEN-1:0] y_in,
  output logic [CNT_LEN-1:0]  index,
  output logic [LIN_LEN-1:0]  sum_x,
  output logic [LIN_LEN-1:0]  sum_y,
  output logic [SQ_LEN-1:0]   sum_xx,
  output logic [SQ_LEN-1:0]   sum_xy,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  localparam int PROD_LEN = 2 * WORD_LEN;
  localparam logic [CNT_LEN-1:0] LAST_IDX = CNT_LEN'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_LEN-1:0] r_index;
  logic [LIN_LEN-1:0] r_sum_x;
  logic [LIN_LEN-1:0] r_sum_y;
  logic [SQ_LEN-1:0]  r_sum_xx;
  logic [SQ_LEN-1:0]  r_sum_xy;

  logic w_in_ready;
  logic w_busy;
  logic w_done;
  logic w_accept;
  logic w_last;
  logic w_clear;

  logic signed [PROD_LEN-1:0] w_prod_xx;
  logic signed [PROD_LEN-1:0] w_prod_xy;
  logic [LIN_LEN-1:0]         w_ext_x;
  logic [LIN_LEN-1:0]         w_ext_y;
  logic [SQ_LEN-1:0]          w_ext_xx;
  logic [SQ_LEN-1:0]          w_ext_xy;

  // Beat acceptance and end-of-run detection.
  assign w_accept = in_valid & w_in_ready;
  assign w_last   = (r_index == LAST_IDX);
  assign w_clear  = (r_state == S_IDLE) & start;

  // Full-width signed products, then sign extension of every addend.
  assign w_prod_xx = $signed(x_in) * $signed(x_in);
  assign w_prod_xy = $signed(x_in) * $signed(y_in);
  assign w_ext_x   = {{(LIN_LEN - WORD_LEN){x_in[WORD_LEN-1]}}, x_in};
  assign w_ext_y   = {{(LIN_LEN - WORD_LEN){y_in[WORD_LEN-1]}}, y_in};
  assign w_ext_xx  = {{(SQ_LEN - PROD_LEN){w_prod_xx[PROD_LEN-1]}}, w_prod_xx};
  assign w_ext_xy  = {{(SQ_LEN - PROD_LEN){w_prod_xy[PROD_LEN-1]}}, w_prod_xy};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start only counts in IDLE; DONE always lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_ACCUM;
      end
      S_ACCUM: begin
        if (w_accept && w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode, purely from the registered state.
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_ACCUM: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Sample index: cleared on run start, wraps modulo N_SAMPLES on accepts.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_index <= '0;
    end else if (w_accept) begin
      r_index <= w_last ? '0 : r_index + 1'b1;
    end
  end

  // Accumulators: cleared on run start, wrapping adds on accepts, else hold.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_sum_x  <= '0;
      r_sum_y  <= '0;
      r_sum_xx <= '0;
      r_sum_xy <= '0;
    end else if (w_accept) begin
      r_sum_x  <= r_sum_x  + w_ext_x;
      r_sum_y  <= r_sum_y  + w_ext_y;
      r_sum_xx <= r_sum_xx + w_ext_xx;
      r_sum_xy <= r_sum_xy + w_ext_xy;
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign done      = w_done;
  assign index     = r_index;
  assign sum_x     = r_sum_x;
  assign sum_y     = r_sum_y;
  assign sum_xx    = r_sum_xx;
  assign sum_xy    = r_sum_xy;
  assign dbg_state = r_state;

endmodule
